// File: rtl/lamp_fpu_sqrt_arbiter.sv
// Two-port round-robin front end for a single fractional sqrt / inverse-sqrt unit.
// One operation in flight; a watchdog turns a silent unit into an error response.
module lamp_fpu_sqrt_arbiter #(
  parameter int S_W     = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_i,
  input  logic [2*S_W-1:0]   s_i,
  input  logic [1:0]         is_exp_odd_i,
  input  logic [1:0]         invSqrt_i,
  input  logic [1:0]         special_case_i,
  output logic [1:0]         ack_o,
  output logic [1:0]         rsp_valid_o,
  input  logic [1:0]         rsp_ready_i,
  output logic [RES_W-1:0]   rsp_res_o,
  output logic               rsp_err_o,
  output logic               doSqrt_o,
  output logic [S_W-1:0]     s_o,
  output logic               is_exp_odd_o,
  output logic               invSqrt_o,
  output logic               special_case_o,
  input  logic               unit_valid_i,
  input  logic [RES_W-1:0]   unit_res_i,
  output logic               busy_o,
  output logic               stray_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               gnt_sel;
  logic               gnt_q;
  logic               last_grant_q;
  logic [9:0]         timer_q;
  logic [S_W-1:0]     s_q;
  logic               odd_q;
  logic               inv_q;
  logic               spc_q;
  logic [RES_W-1:0]   res_q;
  logic               err_q;
  logic               tmo_hit;
  logic               in_resp;

  // Tie goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    if (req_i == 2'b11) gnt_sel = ~last_grant_q;
    else                gnt_sel = req_i[1] & ~req_i[0];
  end

  assign tmo_hit = (timer_q == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_i != 2'b00)                state_nxt = ISSUE;
      ISSUE:                                    state_nxt = WAIT;
      WAIT:  if (unit_valid_i || tmo_hit)       state_nxt = RESP;
      RESP:  if (rsp_ready_i[gnt_q])            state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      timer_q      <= '0;
      s_q          <= '0;
      odd_q        <= 1'b0;
      inv_q        <= 1'b0;
      spc_q        <= 1'b0;
      res_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_i != 2'b00) begin
            gnt_q <= gnt_sel;
            s_q   <= gnt_sel ? s_i[2*S_W-1:S_W] : s_i[S_W-1:0];
            odd_q <= is_exp_odd_i[gnt_sel];
            inv_q <= invSqrt_i[gnt_sel];
            spc_q <= special_case_i[gnt_sel];
          end
        end
        ISSUE: timer_q <= '0;
        WAIT: begin
          timer_q <= timer_q + 10'd1;
          // A unit answer in the timeout cycle still counts as a real result.
          if (unit_valid_i) begin
            res_q <= unit_res_i;
            err_q <= 1'b0;
          end else if (tmo_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        RESP: if (rsp_ready_i[gnt_q]) last_grant_q <= gnt_q;
        default: ;
      endcase
    end
  end

  assign in_resp        = !rst && (state == RESP);
  assign ack_o          = (!rst && state == IDLE && req_i != 2'b00) ?
                          (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign doSqrt_o       = !rst && (state == ISSUE);
  assign rsp_valid_o    = in_resp ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_res_o      = in_resp ? res_q : '0;
  assign rsp_err_o      = in_resp & err_q;
  assign s_o            = rst ? '0 : s_q;
  assign is_exp_odd_o   = !rst & odd_q;
  assign invSqrt_o      = !rst & inv_q;
  assign special_case_o = !rst & spc_q;
  assign busy_o         = !rst && (state != IDLE);
  assign stray_o        = !rst && unit_valid_i && (state != WAIT);

endmodule

// File: tb/tb_lamp_fpu_sqrt_arbiter.sv
// Bench for lamp_fpu_sqrt_arbiter: vector table with a response scoreboard,
// plus hand sequences for timeout strays and mid-operation reset.
module tb_lamp_fpu_sqrt_arbiter;
  localparam int S_W = 8;
  localparam int RES_W = 16;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_i;
  logic [2*S_W-1:0] s_i;
  logic [1:0]       is_exp_odd_i, invSqrt_i, special_case_i;
  logic [1:0]       ack_o, rsp_valid_o, rsp_ready_i;
  logic [RES_W-1:0] rsp_res_o, unit_res_i;
  logic             rsp_err_o, doSqrt_o, is_exp_odd_o, invSqrt_o, special_case_o;
  logic [S_W-1:0]   s_o;
  logic             unit_valid_i, busy_o, stray_o;

  always #5 clk = ~clk;

  lamp_fpu_sqrt_arbiter #(.S_W(S_W), .RES_W(RES_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .s_i(s_i), .is_exp_odd_i(is_exp_odd_i),
    .invSqrt_i(invSqrt_i), .special_case_i(special_case_i), .ack_o(ack_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_res_o(rsp_res_o),
    .rsp_err_o(rsp_err_o), .doSqrt_o(doSqrt_o), .s_o(s_o), .is_exp_odd_o(is_exp_odd_o),
    .invSqrt_o(invSqrt_o), .special_case_o(special_case_o), .unit_valid_i(unit_valid_i),
    .unit_res_i(unit_res_i), .busy_o(busy_o), .stray_o(stray_o)
  );

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  s0, s1;
    logic [1:0]  odd, inv, spc;
    int          dly;      // WAIT cycles before the unit answers; >= TMO means never
    int          rdy_dly;  // RESP cycles with the granted ready held low
    logic [15:0] ures;
    logic [1:0]  exp_ack;
    logic [15:0] exp_res;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [1:0]  port;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  vec_t tmo_vec;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic g;
    exp_t e;
    int   w;
    int   exp_w;
    g     = v.exp_ack[1];
    exp_w = (v.dly < TMO) ? v.dly + 1 : TMO;
    req_i = v.req; s_i = {v.s1, v.s0};
    is_exp_odd_i = v.odd; invSqrt_i = v.inv; special_case_i = v.spc;
    #1;
    chk("ack", 32'(ack_o), 32'(v.exp_ack));
    e.port = v.exp_ack; e.res = v.exp_res; e.err = v.exp_err;
    sb.push_back(e);
    step(); #1;
    chk("doSqrt_issue", 32'(doSqrt_o), 32'd1);
    chk("ack_in_issue", 32'(ack_o), 32'd0);
    chk("s_o", 32'(s_o), 32'(g ? v.s1 : v.s0));
    chk("odd_o", 32'(is_exp_odd_o), 32'(v.odd[g]));
    chk("inv_o", 32'(invSqrt_o), 32'(v.inv[g]));
    chk("spc_o", 32'(special_case_o), 32'(v.spc[g]));
    chk("busy", 32'(busy_o), 32'd1);
    req_i = 2'b00;
    step(); #1;
    chk("doSqrt_once", 32'(doSqrt_o), 32'd0);
    w = 0;
    while (rsp_valid_o == 2'b00 && w < TMO + 4) begin
      if (w == v.dly) begin
        unit_valid_i = 1'b1; unit_res_i = v.ures;
        #1;
        chk("stray_in_wait", 32'(stray_o), 32'd0);
      end
      step();
      unit_valid_i = 1'b0; unit_res_i = '0;
      #1;
      w++;
    end
    chk("wait_cycles", 32'(w), 32'(exp_w));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid_o), 32'(e.port));
      chk("rsp_res", 32'(rsp_res_o), 32'(e.res));
      chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
      for (int i = 0; i < v.rdy_dly; i++) begin
        req_i = 2'b11; rsp_ready_i = ~e.port;
        step(); #1;
        chk("hold_valid", 32'(rsp_valid_o), 32'(e.port));
        chk("hold_res", 32'(rsp_res_o), 32'(e.res));
        chk("hold_err", 32'(rsp_err_o), 32'(e.err));
        chk("hold_ack", 32'(ack_o), 32'd0);
      end
    end
    req_i = 2'b00; rsp_ready_i = v.exp_ack;
    step();
    rsp_ready_i = 2'b00;
    #1;
    chk("post_valid", 32'(rsp_valid_o), 32'd0);
    chk("post_res", 32'(rsp_res_o), 32'd0);
    chk("post_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b01, 8'h80, 8'h00, 2'b00, 2'b00, 2'b00, 0,  0, 16'h8000, 2'b01, 16'h8000, 1'b0};
    vecs[1] = '{2'b10, 8'h00, 8'hC3, 2'b10, 2'b10, 2'b00, 3,  0, 16'h1234, 2'b10, 16'h1234, 1'b0};
    vecs[2] = '{2'b11, 8'hA5, 8'h5A, 2'b01, 2'b00, 2'b01, 1,  0, 16'hBEEF, 2'b01, 16'hBEEF, 1'b0};
    vecs[3] = '{2'b11, 8'h11, 8'h22, 2'b10, 2'b10, 2'b10, 2,  5, 16'h7777, 2'b10, 16'h7777, 1'b0};
    vecs[4] = '{2'b11, 8'h33, 8'h44, 2'b00, 2'b01, 2'b00, 7,  0, 16'h4242, 2'b01, 16'h4242, 1'b0};
    vecs[5] = '{2'b11, 8'h55, 8'h66, 2'b11, 2'b11, 2'b11, 99, 0, 16'hDEAD, 2'b10, 16'h0000, 1'b1};
    vecs[6] = '{2'b01, 8'hFF, 8'h00, 2'b01, 2'b01, 2'b01, 5,  1, 16'hFFFF, 2'b01, 16'hFFFF, 1'b0};
    tmo_vec = '{2'b10, 8'h00, 8'h9A, 2'b00, 2'b00, 2'b00, 99, 0, 16'h0000, 2'b10, 16'h0000, 1'b1};

    rst = 1'b1; req_i = 2'b01; s_i = '1; is_exp_odd_i = 2'b11; invSqrt_i = 2'b11;
    special_case_i = 2'b11; rsp_ready_i = 2'b00; unit_valid_i = 1'b0; unit_res_i = '0;
    step(); step(); #1;
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_doSqrt", 32'(doSqrt_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    req_i = 2'b00; s_i = '0; is_exp_odd_i = '0; invSqrt_i = '0; special_case_i = '0;
    rst = 1'b0;
    step(); #1;
    chk("idle_s_o", 32'(s_o), 32'd0);
    chk("idle_flags", 32'({is_exp_odd_o, invSqrt_o, special_case_o}), 32'd0);
    chk("idle_res", 32'({rsp_err_o, rsp_res_o}), 32'd0);
    chk("idle_stray", 32'(stray_o), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Timeout, then the unit answers late while idle.
    run_vec(tmo_vec);
    unit_valid_i = 1'b1; unit_res_i = 16'h5555;
    #1;
    chk("late_stray", 32'(stray_o), 32'd1);
    chk("late_valid", 32'(rsp_valid_o), 32'd0);
    step(); unit_valid_i = 1'b0; #1;
    chk("late_stray_clear", 32'(stray_o), 32'd0);

    // Reset while waiting on the unit: op dropped, later answer is stray.
    req_i = 2'b01; s_i = 16'h0077;
    step(); req_i = 2'b00;
    step(); #1;
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    rst = 1'b1; #1;
    chk("in_rst_busy", 32'(busy_o), 32'd0);
    step(); rst = 1'b0;
    unit_valid_i = 1'b1; unit_res_i = 16'hAAAA;
    #1;
    chk("rst_stray", 32'(stray_o), 32'd1);
    chk("rst_busy_after", 32'(busy_o), 32'd0);
    chk("rst_no_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_s_o", 32'(s_o), 32'd0);
    step(); unit_valid_i = 1'b0; #1;
    chk("rst_stray_clear", 32'(stray_o), 32'd0);
    step(); #1;
    chk("rst_no_valid_later", 32'(rsp_valid_o), 32'd0);
    req_i = 2'b11; #1;
    chk("rst_tie_port0", 32'(ack_o), 32'd1);
    step(); req_i = 2'b00; #1;
    chk("rst_tie_doSqrt", 32'(doSqrt_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
